// File: rtl/prime_scan_ctrl_pkg.sv
// Shared encodings and widths for the prime-detector scan controller.
package prime_scan_ctrl_pkg;

  localparam int CODE_W = 4;
  localparam int MAP_W  = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prime_scan_ctrl.sv
// Walks a 4-bit code range into the prime detector one code per clock and
// accumulates which codes it flagged; reports with a one-cycle done pulse.
module prime_scan_ctrl
  import prime_scan_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] lo,
  input  logic [CODE_W-1:0] hi,
  input  logic              y_in,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [MAP_W-1:0]  hit_map
);

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   last_q;
  logic [CNT_W-1:0]    count_q;
  logic [MAP_W-1:0]    hit_map_q;
  logic                en_q;
  logic                busy_q;
  logic                done_q;

  logic [CODE_W-1:0]   code_d;
  logic [CNT_W-1:0]    count_d;
  logic [MAP_W-1:0]    hit_map_d;

  // Accumulator update for the code currently on the detector; only consumed in SCAN.
  always_comb begin
    code_d    = code_q + 4'd1;
    count_d   = count_q;
    hit_map_d = hit_map_q;
    if (y_in == 1'b1) begin
      count_d           = count_q + 5'd1;
      hit_map_d[code_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      last_q    <= '0;
      count_q   <= '0;
      hit_map_q <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= ST_SCAN;
            code_q    <= lo;
            last_q    <= hi;
            count_q   <= '0;
            hit_map_q <= '0;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_SCAN: begin
          count_q   <= count_d;
          hit_map_q <= hit_map_d;
          if (code_q == last_q) begin
            state_q <= ST_DONE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            code_q <= code_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The code stays on a..d after the scan; the detector is gated by en.
  assign {a, b, c, d} = code_q;
  assign en           = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign count        = count_q;
  assign hit_map      = hit_map_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed scoreboard bench for prime_scan_ctrl with a behavioural detector.
module tb_prime_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  lo;
  logic [3:0]  hi;
  logic        y_in;
  logic        a, b, c, d;
  logic        en;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic [15:0] hit_map;
  logic        stuck;

  typedef struct packed {
    logic [4:0]  cnt;
    logic [15:0] map;
  } res_t;

  logic [3:0] exp_codes[$];
  res_t       exp_res[$];

  int tests;
  int fails;

  prime_scan_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .lo      (lo),
    .hi      (hi),
    .y_in    (y_in),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .en      (en),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .hit_map (hit_map)
  );

  function automatic logic is_prime(input logic [3:0] code);
    case (code)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_prime = 1'b1;
      default:                              is_prime = 1'b0;
    endcase
  endfunction

  // Outside SCAN the detector output is driven high as noise; it must be ignored.
  assign y_in = stuck ? 1'b1 : (en ? is_prime({a, b, c, d}) : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [3:0] lo_v, input logic [3:0] hi_v, input bit hold,
                          input logic [4:0] ecnt, input logic [15:0] emap, input string tag);
    logic [3:0] diff;
    logic [3:0] ecode;
    res_t       r;
    int         n;
    int         cyc;
    int         scan_cyc;
    bit         seen_done;
    diff = hi_v - lo_v;
    n    = int'(diff) + 1;
    for (int i = 0; i < n; i++) exp_codes.push_back(4'(lo_v + 4'(i)));
    exp_res.push_back('{cnt: ecnt, map: emap});

    @(negedge clk);
    start = 1'b1;
    lo    = lo_v;
    hi    = hi_v;
    cyc       = 0;
    scan_cyc  = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
      end else if (busy) begin
        scan_cyc++;
        check({tag, "_en"}, en, 1'b1);
        if (exp_codes.size() > 0) begin
          ecode = exp_codes.pop_front();
          check({tag, "_code"}, {a, b, c, d}, ecode);
        end else begin
          check({tag, "_extra_scan_cycle"}, {a, b, c, d}, 32'hFFFF_FFFF);
        end
      end
    end
    check({tag, "_done_seen"}, seen_done, 1'b1);
    check({tag, "_start_to_done"}, cyc, n + 1);
    check({tag, "_scan_cycles"}, scan_cyc, n);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_en_in_done"}, en, 1'b0);
    r = exp_res.pop_front();
    check({tag, "_count"}, count, r.cnt);
    check({tag, "_hit_map"}, hit_map, r.map);

    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_stay_idle"}, busy, 1'b0);
    check({tag, "_count_hold"}, count, r.cnt);
    check({tag, "_map_hold"}, hit_map, r.map);
  endtask

  initial begin
    logic [3:0] ecode;
    tests = 0;
    fails = 0;
    stuck = 1'b0;
    start = 1'b0;
    lo    = 4'd0;
    hi    = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {a, b, c, d, en, busy, done}, 7'd0);
    check("reset_count", count, 5'd0);
    check("reset_map", hit_map, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", busy, 1'b0);

    run_scan(4'd0,  4'd15, 1'b0, 5'd6, 16'h28AC, "full");
    run_scan(4'd7,  4'd7,  1'b0, 5'd1, 16'h0080, "single");
    run_scan(4'd14, 4'd3,  1'b0, 5'd2, 16'h000C, "wrap");
    run_scan(4'd4,  4'd6,  1'b1, 5'd1, 16'h0020, "held_start");

    // Abort a full scan during its third SCAN cycle.
    for (int i = 0; i < 3; i++) exp_codes.push_back(4'(i));
    @(negedge clk);
    start = 1'b1;
    lo    = 4'd0;
    hi    = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_busy", busy, 1'b1);
      ecode = exp_codes.pop_front();
      check("abort_code", {a, b, c, d}, ecode);
    end
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {a, b, c, d, en, busy, done}, 7'd0);
    check("abort_count", count, 5'd0);
    check("abort_map", hit_map, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_done", {busy, done}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", {busy, done}, 2'b00);
    run_scan(4'd0, 4'd15, 1'b0, 5'd6, 16'h28AC, "after_abort");

    stuck = 1'b1;
    run_scan(4'd0, 4'd15, 1'b0, 5'd16, 16'hFFFF, "stuck");
    stuck = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prime_scan_ctrl.md
# prime_scan_ctrl

Sequencing controller that sits directly upstream of the 4-input prime-detector function, which is decoder-based (`y` high for codes 2, 3, 5, 7, 11 and 13). On a start request it drives the detector's `a,b,c,d,en` inputs through a programmable 4-bit code range, one code per clock. On the same cycle it samples the detector's `y` back. It accumulates a 16-bit hit map and a hit count, then reports completion with a one-cycle done pulse.

## Interface
Parameters: none. Code width is fixed at 4 bits by the detector.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  scan request; sampled only in IDLE.
- `lo`  in  4  first code of the scan; sampled when start is accepted.
- `hi`  in  4  last code of the scan; sampled when start is accepted.
- `y_in`  in  1  detector output `y`; combinational from `a,b,c,d,en`.
- `a`, `b`, `c`, `d`  out  1 each  code to the detector; `a` is the MSB (code[3]) and `d` is the LSB (code[0]).
- `en`  out  1  detector enable; high only in SCAN.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse in DONE.
- `count`  out  5  number of hits in the last scan (0..16).
- `hit_map`  out  16  bit k set if code k produced `y_in=1` in the last scan.

## Operation
- **FSM states:** IDLE, SCAN, DONE. Encoding is 2-bit binary (IDLE=0, SCAN=1, DONE=2); 3 is illegal and recovers to IDLE.
- **IDLE:**
  - `en=0`, `busy=0`, `done=0`.
  - `start=1` at a clock edge is accepted: latch `lo` into `code` and `hi` into `last`, clear `count` and `hit_map`, go to SCAN.
- **SCAN:**
  - `en=1`, `busy=1`, and `{a,b,c,d}=code`.
  - Each edge samples `y_in`. If `y_in=1`: set `hit_map[code]` and increment `count`.
  - If `code==last`, go to DONE. Otherwise `code <= code+1` modulo 16.
- **Wrap-around:** when `lo>hi` the scan is lo..15,0..hi. When `lo==hi` exactly one code is scanned. A full 16-code scan is requested as `lo=hi+1` (mod 16), e.g. lo=0, hi=15.
- **Count:** 5 bits, so 16 hits never overflows. No code is visited twice within one scan.
- **DONE:**
  - `done=1`, `busy=0`, `en=0`. Unconditionally return to IDLE next edge.
  - `start` is ignored in DONE and SCAN; no queuing.
- **Result hold:** `count` and `hit_map` hold their values from the end of SCAN until the next accepted start.
- **Outputs outside SCAN:** `{a,b,c,d}` keeps the last driven code; the detector is gated off by `en=0`.
- **Reset:**
  - Values: state=IDLE, `code=0`, `last=0`, `count=0`, `hit_map=0`, `a=b=c=d=0`, `en=0`, `busy=0`, `done=0`.
  - Reset asserted mid-SCAN aborts the scan immediately, with no done pulse.
- **Unknowns:** `y_in` is ignored outside SCAN, so X on it there must not corrupt results.

## Timing
- All outputs are registered or decoded from registered state only.
- Start accepted at edge 0 → SCAN with `code=lo` visible after edge 0.
- With N = ((hi−lo) mod 16)+1 codes, edges 1..N sample `y_in` for successive codes. DONE is entered after edge N; `done` is high between edges N and N+1. IDLE follows after edge N+1.
- Start-to-done: N+1 cycles. A back-to-back start is accepted at edge N+2 at the earliest.
- `count`/`hit_map` are final when `done` rises.
- The combinational path `code → detector → y_in` must close within one clock period.

## Structure
- **Shared package/header:** state encodings (IDLE/SCAN/DONE), CODE_W=4, MAP_W=16, CNT_W=5.
- **Single module:** FSM, code counter and accumulators in one module. No sub-module is needed.
- **Top level:** the system top instantiates `prime_scan_ctrl` alongside `myfunction`, wiring `a,b,c,d,en` to the detector and `y` to `y_in`.

## Test plan
- **Full scan:** lo=0, hi=15, real detector attached, pulse start → busy for 16 cycles, done one cycle later, count=6, hit_map=0x28AC.
- **Single code:** lo=hi=7 → exactly one SCAN cycle with `{a,b,c,d}=4'b0111` and en=1 → count=1, hit_map=0x0080, done at start+2.
- **Wrap:** lo=14, hi=3 → codes 14,15,0,1,2,3 driven in order over 6 cycles → count=2, hit_map=0x000C.
- **Start while busy/done:** start held high through an entire lo=4, hi=6 scan → start ignored in SCAN and DONE. Results count=1, hit_map=0x0020, and a new scan begins only from IDLE.
- **Reset mid-scan:** assert rst_n=0 at the 3rd SCAN cycle of a lo=0, hi=15 scan → all outputs 0 immediately, no done pulse. After release, a fresh lo=0, hi=15 scan gives count=6.
- **Stuck-high y:** force `y_in=1`, lo=0, hi=15 → count=16 (no overflow), hit_map=0xFFFF.
